// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder.
//   DATASIZE_DEFAULT : default signed operand width (must match PE_unit)
//   N                : array dimension, fixed at 4 by the PE_unit port list
//   STREAM_LEN       : cycles needed to push one skewed tile through (3N-2)
//   LANE_W / T_W     : widths of the lane index and the stream time counter
//   state_t          : feeder FSM states
package systolic_skew_feeder_pkg;

  localparam int DATASIZE_DEFAULT = 2;
  localparam int N                = 4;
  localparam int STREAM_LEN       = 3 * N - 2;
  localparam int LANE_W           = $clog2(N);
  localparam int T_W              = 4;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/systolic_skew_feeder_skew_lane_sel.sv
// Skew selector for one array lane.
// Given the N buffered elements of a lane (one per loaded beat), the lane index
// and the stream time t, returns the element that enters the array at time t,
// or zero when the lane is outside its skew window (t-lane not in 0..N-1).
//   lane_vals : element of this lane for beat 0..N-1 (beat k at index k)
//   lane      : lane index i (the skew delay in cycles)
//   t         : stream time
//   en        : high only while streaming; forces zero otherwise
//   elem      : selected element, bit-exact
module skew_lane_sel
  import systolic_skew_feeder_pkg::*;
#(
  parameter int datasize = DATASIZE_DEFAULT
) (
  input  logic [N-1:0][datasize-1:0] lane_vals,
  input  logic [LANE_W-1:0]          lane,
  input  logic [T_W-1:0]             t,
  input  logic                       en,
  output logic [datasize-1:0]        elem
);

  // One extra bit so that t < lane shows up as a set MSB (negative offset).
  logic [T_W:0] d;

  always_comb begin
    elem = '0;
    d    = {1'b0, t} - {{(T_W + 1 - LANE_W){1'b0}}, lane};
    if (en && !d[T_W] && (d[T_W-1:0] < T_W'(N))) begin
      elem = lane_vals[d[LANE_W-1:0]];
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Transmit side of the 4x4 PE_unit array interface.
// Loads one tile (N beats) over a valid/ready stream, pulses array_rst for one
// cycle, streams skewed zero-padded rows/columns for STREAM_LEN cycles, drains
// with zeros for DRAIN_CYCLES cycles, then pulses tile_done.
// Ports:
//   clk, reset         : single clock, synchronous active-high reset
//   in_valid/in_ready  : operand beat handshake
//   in_a               : beat k = A column k, lane i = A[i][k], lane 0 in LSBs
//   in_b               : beat k = B row k,    lane j = B[k][j], lane 0 in LSBs
//   array_rst          : one-cycle clear of the PE_unit accumulators
//   a1..a4, b1..b4     : skewed operand streams to PE_unit
//   busy               : high outside LOAD
//   tile_done          : one-cycle pulse, PE_unit outputs are final
//   state              : current FSM state (debug observation)
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready;
// in_ready is high only in LOAD and does not depend on in_valid, and in_valid
// is ignored whenever in_ready is low.
// All outputs are flops; each is loaded with the value implied by the next
// state so it lines up with that state.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int datasize     = DATASIZE_DEFAULT,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*datasize-1:0]      in_a,
  input  logic [N*datasize-1:0]      in_b,
  output logic                       array_rst,
  output logic signed [datasize-1:0] a1,
  output logic signed [datasize-1:0] a2,
  output logic signed [datasize-1:0] a3,
  output logic signed [datasize-1:0] a4,
  output logic signed [datasize-1:0] b1,
  output logic signed [datasize-1:0] b2,
  output logic signed [datasize-1:0] b3,
  output logic signed [datasize-1:0] b4,
  output logic                       busy,
  output logic                       tile_done,
  output state_t                     state
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   beat_q, beat_d;
  logic [T_W-1:0]      t_q, t_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic                accept;
  logic                stream_d;

  logic [N*datasize-1:0]       buf_a [N];
  logic [N*datasize-1:0]       buf_b [N];
  logic [N-1:0][datasize-1:0]  a_sel, b_sel;
  logic [N-1:0][datasize-1:0]  a_q, b_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    t_d     = t_q;
    drain_d = drain_q;
    accept  = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (in_valid && in_ready) begin
          accept = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LANE_W'(N - 1)) begin
            state_d = CLEAR;
            beat_d  = '0;
          end
        end
      end
      CLEAR: begin
        state_d = STREAM;
        t_d     = '0;
      end
      STREAM: begin
        // t stops at its last value; it is cleared again in CLEAR.
        if (t_q == T_W'(STREAM_LEN - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = LOAD;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  assign stream_d = (state_d == STREAM);

  // Lane selectors look at next-cycle t so the registered outputs carry the
  // element for the t that is current when they appear.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [N-1:0][datasize-1:0] a_col, b_col;
    for (genvar k = 0; k < N; k++) begin : g_beat
      assign a_col[k] = buf_a[k][i*datasize +: datasize];
      assign b_col[k] = buf_b[k][i*datasize +: datasize];
    end
    skew_lane_sel #(.datasize(datasize)) u_a_sel (
      .lane_vals (a_col),
      .lane      (LANE_W'(i)),
      .t         (t_d),
      .en        (stream_d),
      .elem      (a_sel[i])
    );
    skew_lane_sel #(.datasize(datasize)) u_b_sel (
      .lane_vals (b_col),
      .lane      (LANE_W'(i)),
      .t         (t_d),
      .en        (stream_d),
      .elem      (b_sel[i])
    );
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOAD;
      beat_q    <= '0;
      t_q       <= '0;
      drain_q   <= '0;
      in_ready  <= 1'b1;
      array_rst <= 1'b0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      t_q       <= t_d;
      drain_q   <= drain_d;
      in_ready  <= (state_d == LOAD);
      array_rst <= (state_d == CLEAR);
      busy      <= (state_d != LOAD);
      tile_done <= (state_d == DONE);
      a_q       <= a_sel;
      b_q       <= b_sel;
    end
  end

  // Operand buffer; contents are don't-care until a full tile is loaded.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      buf_a[beat_q] <= in_a;
      buf_b[beat_q] <= in_b;
    end
  end

  assign a1    = a_q[0];
  assign a2    = a_q[1];
  assign a3    = a_q[2];
  assign a4    = a_q[3];
  assign b1    = b_q[0];
  assign b2    = b_q[1];
  assign b3    = b_q[2];
  assign b4    = b_q[3];
  assign state = state_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (datasize=2, DRAIN_CYCLES=8).
module tb_systolic_skew_feeder;
  import systolic_skew_feeder_pkg::*;

  localparam int DS      = 2;
  localparam int DRAIN_N = 8;

  // Clock / reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a, in_b;
  logic          array_rst;
  logic signed [DS-1:0] a1, a2, a3, a4, b1, b2, b3, b4;
  logic          busy, tile_done;
  state_t        state;

  systolic_skew_feeder #(.datasize(DS), .DRAIN_CYCLES(DRAIN_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .array_rst (array_rst),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .a4        (a4),
    .b1        (b1),
    .b2        (b2),
    .b3        (b3),
    .b4        (b4),
    .busy      (busy),
    .tile_done (tile_done),
    .state     (state)
  );

  int checks = 0;
  int errors = 0;

  // Tile under test: ma[i][k] = A[i][k], mb[k][j] = B[k][j].
  logic [1:0]  ma [4][4];
  logic [1:0]  mb [4][4];
  logic [15:0] seen [10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bus_now();
    return {a1, a2, a3, a4, b1, b2, b3, b4};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {4'b0, 1'b0, state, array_rst, in_ready, busy, tile_done, 4'b0, bus_now()};
  endfunction

  function automatic logic [31:0] mk(input state_t s, input logic r, input logic rd,
                                     input logic bz, input logic dn, input logic [15:0] bus);
    return {4'b0, 1'b0, s, r, rd, bz, dn, 4'b0, bus};
  endfunction

  // a(i+1) at time t is A[i][t-i]; b(j+1) is B[t-j][j]; zero outside the window.
  function automatic logic [15:0] exp_bus(input int t);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (t - i >= 0 && t - i < 4) begin
        r[15-2*i -: 2] = ma[i][t-i];
        r[7-2*i -: 2]  = mb[t-i][i];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] beat_a(input int k);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = ma[i][k];
    return r;
  endfunction

  function automatic logic [7:0] beat_b(input int k);
    logic [7:0] r;
    for (int j = 0; j < 4; j++) r[2*j +: 2] = mb[k][j];
    return r;
  endfunction

  // Driver: called at a negedge with in_ready observable; vpat bit n is the
  // valid for the n-th cycle. Returns at the negedge after the 4th accept.
  task automatic send_tile(input string tag, input logic [15:0] vpat, input int exp_cycles);
    int   k;
    int   n;
    logic v;
    logic acc;
    k = 0;
    n = 0;
    while (k < 4 && n < 40) begin
      v = (n < 16) ? vpat[n] : 1'b1;
      in_valid = v;
      if (v) begin
        in_a = beat_a(k);
        in_b = beat_b(k);
      end else begin
        in_a = 8'($urandom);
        in_b = 8'($urandom);
      end
      acc = v && in_ready;
      @(negedge clk);
      n++;
      if (acc) k++;
    end
    check({tag, "_beats"}, 32'(k), 32'd4);
    check({tag, "_load_cycles"}, 32'(n), 32'(exp_cycles));
  endtask

  // Checks offsets o=1..last_o after the last accept (c0+o), one per cycle.
  task automatic check_tile(input string tag, input int last_o);
    logic [31:0] e;
    for (int o = 1; o <= last_o; o++) begin
      if (o == 1)                e = mk(CLEAR, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
      else if (o <= 11)          e = mk(STREAM, 1'b0, 1'b0, 1'b1, 1'b0, exp_bus(o - 2));
      else if (o <= 11 + DRAIN_N) e = mk(DRAIN, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      else if (o == 12 + DRAIN_N) e = mk(DONE, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
      else                       e = mk(LOAD, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      if (o >= 2 && o <= 11) seen[o-2] = bus_now();
      check($sformatf("%s_o%0d", tag, o), obs_vec(), e);
      if (o < last_o) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset.
    reset    = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_release", obs_vec(), mk(LOAD, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0));
    repeat (2) @(negedge clk);
    check("idle", obs_vec(), mk(LOAD, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0));

    // 2. Identity tiles.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = (i == k) ? 2'd1 : 2'd0;
        mb[i][k] = (i == k) ? 2'd1 : 2'd0;
      end
    send_tile("ident", 16'hFFFF, 4);
    in_valid = 1'b0;
    check_tile("ident", 21);
    check("ident_t0", 32'(seen[0]), 32'h4040);
    check("ident_t1", 32'(seen[1]), 32'h0000);
    check("ident_t2", 32'(seen[2]), 32'h1010);
    check("ident_t4", 32'(seen[4]), 32'h0404);
    check("ident_t6", 32'(seen[6]), 32'h0101);
    check("ident_t9", 32'(seen[9]), 32'h0000);

    // 3. All elements -2.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = 2'b10;
        mb[i][k] = 2'b10;
      end
    send_tile("neg2", 16'hFFFF, 4);
    in_valid = 1'b0;
    check_tile("neg2", 21);
    check("neg2_t0", 32'(seen[0]), 32'h8080);
    check("neg2_t3", 32'(seen[3]), 32'hAAAA);
    check("neg2_t6", 32'(seen[6]), 32'h0202);
    check("neg2_t7", 32'(seen[7]), 32'h0000);
    check("neg2_a4_sign", 32'($signed(a4) == -2), 32'd0);

    // 5. Bubbles: valid 1,0,1,0,0,1,1.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = 2'(i + k);
        mb[i][k] = 2'(3 * i + k + 1);
      end
    send_tile("bubble", 16'h0065, 7);
    in_valid = 1'b0;
    check_tile("bubble", 21);

    // 4. in_valid held high across two back-to-back tiles.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = 2'(i ^ k);
        mb[i][k] = 2'(i - k);
      end
    send_tile("hold1", 16'hFFFF, 4);
    check_tile("hold1", 21);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = 2'(i * k);
        mb[i][k] = 2'(k + 2 * i);
      end
    send_tile("hold2", 16'hFFFF, 4);
    in_valid = 1'b0;
    check_tile("hold2", 21);

    // 6. Reset while streaming at t=5, then a fresh tile.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = 2'($urandom_range(0, 3));
        mb[i][k] = 2'($urandom_range(0, 3));
      end
    send_tile("abort", 16'hFFFF, 4);
    in_valid = 1'b0;
    check_tile("abort", 7);
    reset = 1'b1;
    @(negedge clk);
    check("abort_reset", obs_vec(), mk(LOAD, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0));
    reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d", c), obs_vec(), mk(LOAD, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0));
    end
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = 2'($urandom_range(0, 3));
        mb[i][k] = 2'($urandom_range(0, 3));
      end
    send_tile("fresh", 16'hFFFF, 4);
    check_tile("fresh", 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
